// File: rtl/seq_alu_pkg.sv
// Shared opcode and FSM encodings for the seq_alu block.
// Opcode values are WIDTH-independent so producers can share this package.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_NOT = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SLT = 4'b0110;
    localparam logic [3:0] OP_EQ  = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // SLT reuses the subtractor, so both opcodes steer the adder into subtract mode.
    function automatic logic op_uses_sub(input logic [3:0] op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/seq_alu_addsub.sv
// Combinational WIDTH-bit adder/subtractor shared by ADD, SUB and SLT.
// Subtraction is a + ~b + 1; carry-out then means "no borrow".
module seq_alu_addsub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic [WIDTH:0]   ext;

    always_comb begin
        b_eff    = sub ? ~b : b;
        c0       = sub ? 1'b1 : cin;
        ext      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c0};
        sum      = ext[WIDTH-1:0];
        carry    = ext[WIDTH];
        // Operands of equal sign producing a result of the other sign.
        overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready on both sides; results held until accepted.
// Define SEQ_ALU_MUL_EN to enable the iterative shift-add multiplier (opcode 1000).
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic             in_c,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_c,
    output logic             zero,
    output logic             overflow,
    output logic             negative,
    output logic             err
);

    state_t state;
    state_t state_nxt;
    logic   accept;
    logic   op_is_mul;

    logic [WIDTH-1:0] as_sum;
    logic             as_carry;
    logic             as_ovf;

    logic [WIDTH-1:0] alu_s;
    logic             alu_c;
    logic             alu_v;
    logic             alu_err;

    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;

    seq_alu_addsub #(
        .WIDTH(WIDTH)
    ) u_addsub (
        .a       (in_x),
        .b       (in_y),
        .sub     (op_uses_sub(in_op)),
        .cin     (in_c),
        .sum     (as_sum),
        .carry   (as_carry),
        .overflow(as_ovf)
    );

    // Single-cycle result, computed straight from the presented operands.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        alu_s   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (in_op)
            OP_ADD, OP_SUB: begin
                alu_s = as_sum;
                alu_c = as_carry;
                alu_v = as_ovf;
            end
            OP_NOT: alu_s = ~in_x;
            OP_AND: alu_s = in_x & in_y;
            OP_OR:  alu_s = in_x | in_y;
            OP_XOR: alu_s = in_x ^ in_y;
            OP_SLT: alu_s = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_ovf};
            OP_EQ:  alu_s = {{(WIDTH-1){1'b0}}, in_x == in_y};
`ifdef SEQ_ALU_MUL_EN
            OP_MUL: alu_err = 1'b0;
`endif
            default: alu_err = 1'b1;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0] mul_mcand;
    logic [WIDTH-1:0] mul_mplier;
    logic [WIDTH-1:0] mul_acc_nxt;
    logic [CNT_W-1:0] mul_cnt;
    logic             mul_last;

    assign op_is_mul   = (in_op == OP_MUL);
    assign mul_acc_nxt = mul_mplier[0] ? (mul_acc + mul_mcand) : mul_acc;
    assign mul_last    = (mul_cnt == CNT_W'(WIDTH - 1));

    // One multiplier bit per EXEC cycle; only the low WIDTH product bits are kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_cnt    <= '0;
        end else if (accept && op_is_mul) begin
            mul_acc    <= '0;
            mul_mcand  <= in_x;
            mul_mplier <= in_y;
            mul_cnt    <= '0;
        end else if (state == ST_EXEC) begin
            mul_acc    <= mul_acc_nxt;
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_cnt    <= mul_cnt + 1'b1;
        end
    end
`else
    assign op_is_mul = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_nxt = op_is_mul ? ST_EXEC : ST_DONE;
                end else if ((state == ST_DONE) && out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
`ifdef SEQ_ALU_MUL_EN
            ST_EXEC: begin
                if (mul_last) begin
                    state_nxt = ST_DONE;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Output registers change only when a new result lands, so a stalled consumer sees them frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the result registers are reset too, because they are visible outputs with defined reset values.
            out_s    <= '0;
            out_c    <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            negative <= 1'b0;
            err      <= 1'b0;
        end else if (accept && !op_is_mul) begin
            out_s    <= alu_s;
            out_c    <= alu_c;
            zero     <= (alu_s == '0);
            overflow <= alu_v;
            negative <= alu_s[WIDTH-1];
            err      <= alu_err;
        end
`ifdef SEQ_ALU_MUL_EN
        else if ((state == ST_EXEC) && mul_last) begin
            out_s    <= mul_acc_nxt;
            out_c    <= 1'b0;
            zero     <= (mul_acc_nxt == '0);
            overflow <= 1'b0;
            negative <= mul_acc_nxt[WIDTH-1];
            err      <= 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu at WIDTH=4: directed vectors plus a scoreboard model.
// Multiplier tests are included when SEQ_ALU_MUL_EN is defined.
module tb_seq_alu;
    import seq_alu_pkg::*;

    typedef struct packed {
        logic [3:0] s;
        logic       c;
        logic       z;
        logic       v;
        logic       n;
        logic       e;
    } res_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_op;
    logic       in_c;
    logic [3:0] in_x;
    logic [3:0] in_y;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_s;
    logic       out_c;
    logic       zero;
    logic       overflow;
    logic       negative;
    logic       err;
    logic [8:0] dut_res;

    int   n_tests = 0;
    int   n_fail  = 0;
    res_t sb[$];

    assign dut_res = {out_s, out_c, zero, overflow, negative, err};

    seq_alu #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_c     (in_c),
        .in_x     (in_x),
        .in_y     (in_y),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_s    (out_s),
        .out_c    (out_c),
        .zero     (zero),
        .overflow (overflow),
        .negative (negative),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic res_t pk(input logic [3:0] s, input logic c, input logic z,
                                input logic v, input logic n, input logic e);
        res_t r;
        r.s = s; r.c = c; r.z = z; r.v = v; r.n = n; r.e = e;
        return r;
    endfunction

    // Reference model: plain integer arithmetic on unsigned and signed views of the operands.
    function automatic res_t model(input logic [3:0] op, input logic [3:0] x,
                                   input logic [3:0] y, input logic c);
        int ux, uy, sx, sy, full, sres;
        res_t r;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= 8) ? ux - 16 : ux;
        sy = (uy >= 8) ? uy - 16 : uy;
        r  = '0;
        case (op)
            OP_ADD: begin
                full = ux + uy + int'(c);
                sres = sx + sy + int'(c);
                r.s  = 4'(full);
                r.c  = (full >= 16);
                r.v  = (sres > 7) || (sres < -8);
            end
            OP_SUB: begin
                full = ux - uy;
                sres = sx - sy;
                r.s  = 4'(full);
                r.c  = (ux >= uy);
                r.v  = (sres > 7) || (sres < -8);
            end
            OP_NOT: r.s = 4'(15 - ux);
            OP_AND: r.s = x & y;
            OP_OR:  r.s = x | y;
            OP_XOR: r.s = x ^ y;
            OP_SLT: r.s = (sx < sy) ? 4'd1 : 4'd0;
            OP_EQ:  r.s = (ux == uy) ? 4'd1 : 4'd0;
`ifdef SEQ_ALU_MUL_EN
            OP_MUL: r.s = 4'(ux * uy);
`endif
            default: r.e = 1'b1;
        endcase
        r.z = (r.s == 4'd0);
        r.n = r.s[3];
        return r;
    endfunction

    // Scoreboard: compare whenever a result is presented, retire on handshake, enqueue on accept.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_valid", out_valid, 0);
                end else begin
                    check("scoreboard", dut_res, sb[0]);
                    if (out_ready) void'(sb.pop_front());
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_op, in_x, in_y, in_c));
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [3:0] x, input logic [3:0] y, input logic c);
        int k;
        k = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_x     = x;
        in_y     = y;
        in_c     = c;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check("send_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input logic [3:0] op, input logic [3:0] x, input logic [3:0] y,
                           input logic c, input res_t exp);
        send(op, x, y, c);
        check($sformatf("lat1_valid_op%0h", op), out_valid, 1);
        check($sformatf("vec_op%0h_%0h_%0h", op, x, y), dut_res, exp);
        @(posedge clk);
        #1;
    endtask

`ifdef SEQ_ALU_MUL_EN
    task automatic mul_vec(input logic [3:0] x, input logic [3:0] y, input res_t exp, input bit hold_add);
        int cyc;
        cyc = 0;
        send(OP_MUL, x, y, 1'b0);
        if (hold_add) begin
            in_valid = 1'b1; in_op = OP_ADD; in_x = 4'd1; in_y = 4'd2; in_c = 1'b0;
        end
        while (!out_valid && cyc < 20) begin
            check("mul_exec_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
            cyc++;
        end
        check("mul_latency", cyc, 4);
        check($sformatf("mul_%0dx%0d", x, y), dut_res, exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (hold_add) begin
            check("held_add_valid", out_valid, 1);
            check("held_add_res", dut_res, pk(4'd3, 0, 0, 0, 0, 0));
            @(posedge clk);
            #1;
        end
    endtask
`endif

    initial begin
        #100000;
        $display("[TB] watchdog expired at %0t", $time);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = 4'd0; in_x = 4'd0; in_y = 4'd0; in_c = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_outputs", dut_res, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors with hand-computed results {s, c, z, v, n, e}.
        run_vec(OP_ADD, 4'd7,  4'd1,  1'b0, pk(4'd8,  0, 0, 1, 1, 0));
        run_vec(OP_SUB, 4'd3,  4'd5,  1'b0, pk(4'd14, 0, 0, 0, 1, 0));
        run_vec(OP_SUB, 4'd5,  4'd5,  1'b0, pk(4'd0,  1, 1, 0, 0, 0));
        run_vec(OP_SLT, 4'hE,  4'd1,  1'b0, pk(4'd1,  0, 0, 0, 0, 0));
        run_vec(OP_EQ,  4'd9,  4'd9,  1'b0, pk(4'd1,  0, 0, 0, 0, 0));
        run_vec(4'hF,   4'd3,  4'd4,  1'b0, pk(4'd0,  0, 1, 0, 0, 1));
        run_vec(OP_ADD, 4'hF,  4'hF,  1'b1, pk(4'd15, 1, 0, 0, 1, 0));
        run_vec(OP_NOT, 4'd5,  4'd0,  1'b0, pk(4'd10, 0, 0, 0, 1, 0));
        run_vec(OP_AND, 4'hC,  4'hA,  1'b0, pk(4'd8,  0, 0, 0, 1, 0));
        run_vec(OP_OR,  4'hC,  4'hA,  1'b0, pk(4'd14, 0, 0, 0, 1, 0));
        run_vec(OP_XOR, 4'hC,  4'hA,  1'b0, pk(4'd6,  0, 0, 0, 0, 0));
        run_vec(OP_SLT, 4'd1,  4'hE,  1'b0, pk(4'd0,  0, 1, 0, 0, 0));
        run_vec(OP_EQ,  4'd3,  4'd4,  1'b0, pk(4'd0,  0, 1, 0, 0, 0));
        run_vec(OP_SUB, 4'd8,  4'd1,  1'b0, pk(4'd7,  1, 0, 1, 0, 0));
        run_vec(OP_ADD, 4'd0,  4'd0,  1'b1, pk(4'd1,  0, 0, 0, 0, 0));
        run_vec(4'h9,   4'd1,  4'd1,  1'b0, pk(4'd0,  0, 1, 0, 0, 1));
`ifndef SEQ_ALU_MUL_EN
        run_vec(OP_MUL, 4'd3,  4'd5,  1'b0, pk(4'd0,  0, 1, 0, 0, 1));
`endif

        // Consumer stall: result must hold and no new transaction may enter.
        out_ready = 1'b0;
        send(OP_ADD, 4'd2, 4'd3, 1'b0);
        in_valid = 1'b1; in_op = OP_ADD; in_x = 4'd1; in_y = 4'd1; in_c = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_valid", out_valid, 1);
            check("stall_hold", dut_res, pk(4'd5, 0, 0, 0, 0, 0));
        end
        @(posedge clk);
        #1;

        // Back-to-back: one accept and one result per cycle; order checked by the scoreboard.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_op = OP_ADD; in_x = 4'(i + 1); in_y = 4'(3 * i + 1); in_c = 1'b0;
            @(negedge clk);
            check("b2b_in_ready", in_ready, 1);
            check("b2b_out_valid", out_valid, 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("b2b_last_res", dut_res, pk(4'd2, 1, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check("b2b_idle", out_valid, 0);

`ifdef SEQ_ALU_MUL_EN
        mul_vec(4'd3, 4'd5, pk(4'd15, 0, 0, 0, 1, 0), 1'b1);
        mul_vec(4'd7, 4'd3, pk(4'd5,  0, 0, 0, 0, 0), 1'b0);
        mul_vec(4'd4, 4'd4, pk(4'd0,  0, 1, 0, 0, 0), 1'b0);
        mul_vec(4'd7, 4'd3, pk(4'd5,  0, 0, 0, 0, 0), 1'b0);

        // Reset in the middle of a multiply discards it.
        send(OP_MUL, 4'd7, 4'd7, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("rst_exec_valid", out_valid, 0);
        check("rst_exec_outputs", dut_res, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_vec(OP_ADD, 4'd4, 4'd3, 1'b0, pk(4'd7, 0, 0, 0, 0, 0));
`endif

        // Reset while a result waits in DONE discards it.
        out_ready = 1'b0;
        send(OP_ADD, 4'd6, 4'd6, 1'b0);
        check("pre_rst_done", dut_res, pk(4'd12, 0, 0, 1, 1, 0));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_done_valid", out_valid, 0);
        check("rst_done_outputs", dut_res, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        run_vec(OP_ADD, 4'd4, 4'd3, 1'b0, pk(4'd7, 0, 0, 0, 0, 0));

        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("drain_sb", sb.size(), 0);
        check("drain_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
